// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: pipeline WB request, long-op valid/ready offer,
// regfile write port and hazard-unit status.
interface wb_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic            regwrite_w;
  logic [4:0]      rd_w;
  logic [XLEN-1:0] result_w;
  logic            lo_valid;
  logic            lo_ready;
  logic [4:0]      lo_rd;
  logic [XLEN-1:0] lo_data;
  logic            we3;
  logic [4:0]      a3;
  logic [XLEN-1:0] wd3;
  logic [31:0]     pend_mask;
  logic [CW-1:0]   buf_count;

  modport master (
    output regwrite_w, rd_w, result_w, lo_valid, lo_rd, lo_data,
    input  lo_ready, we3, a3, wd3, pend_mask, buf_count
  );

  modport slave (
    input  regwrite_w, rd_w, result_w, lo_valid, lo_rd, lo_data,
    output lo_ready, we3, a3, wd3, pend_mask, buf_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Regfile write-port arbiter: pipeline WB has priority, long-op results buffer
// in an in-order FIFO and drain into free slots; latency 0 (pass-through) or queued.
// Backpressure: lo_ready drops when the buffer is full and nothing pops this cycle.
module wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input logic         clk,
  input logic         reset,
  wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [4:0]      rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;

  logic busy, empty, head_vld, pop, pass, accept, push, push_vld;

  always_comb begin
    busy     = bus.regwrite_w && (bus.rd_w != 5'd0);
    empty    = (count_q == '0);
    head_vld = !empty && vld_q[head_q];
    // Killed heads pop even under a busy slot; valid heads need a free slot.
    pop      = !reset && !empty && (!vld_q[head_q] || !busy);
    pass     = !reset && !busy && empty && bus.lo_valid && (bus.lo_rd != 5'd0);
    bus.lo_ready = !reset && ((count_q < DEPTH_C) || pop);
    accept   = bus.lo_valid && bus.lo_ready;
    push     = accept && (bus.lo_rd != 5'd0) && !pass;
    push_vld = !(busy && (bus.lo_rd == bus.rd_w));
  end

  always_comb begin
    bus.we3 = 1'b0;
    bus.a3  = 5'd0;
    bus.wd3 = '0;
    if (!reset) begin
      if (busy) begin
        bus.we3 = 1'b1;
        bus.a3  = bus.rd_w;
        bus.wd3 = bus.result_w;
      end else if (head_vld) begin
        bus.we3 = 1'b1;
        bus.a3  = rd_q[head_q];
        bus.wd3 = data_q[head_q];
      end else if (pass) begin
        bus.we3 = 1'b1;
        bus.a3  = bus.lo_rd;
        bus.wd3 = bus.lo_data;
      end
    end
  end

  always_comb begin
    bus.pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) bus.pend_mask[rd_q[i]] = 1'b1;
    end
    bus.pend_mask[0] = 1'b0;
  end

  assign bus.buf_count = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // Younger pipeline write to the same register kills buffered results.
      for (int i = 0; i < DEPTH; i++) begin
        if (busy && vld_q[i] && (rd_q[i] == bus.rd_w)) vld_q[i] <= 1'b0;
      end
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + 1'b1;
      end
      // Push last so a full-buffer push into the slot being popped wins.
      if (push) begin
        vld_q[tail_q]  <= push_vld;
        rd_q[tail_q]   <= bus.lo_rd;
        data_q[tail_q] <= bus.lo_data;
        tail_q         <= tail_q + 1'b1;
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end
endmodule
